// File: rtl/mips_single_cycle.sv
// Single-cycle 32-bit MIPS core with on-chip instruction/data memories.
// Every instruction fetches, executes and commits within one clk period.

module mips_imem #(
  parameter int WORDS = 256
) (
  input  logic [31:0] addr,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(WORDS);

  // Loaded from outside the core (bench or backdoor); the core only reads it.
  logic [31:0] imem [0:WORDS-1];

  assign rdata = imem[addr[AW+1:2]];

  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module mips_dmem #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(WORDS);

  logic [31:0] dmem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      dmem[addr[AW+1:2]] <= wdata;
    end
  end

  assign rdata = dmem[addr[AW+1:2]];

  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
endmodule

module mips_single_cycle #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] pc_next;
  logic [31:0] instr;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  logic        reg_write;
  logic [1:0]  dst_sel;
  logic        alu_b_imm;
  logic        imm_zext;
  logic [3:0]  alu_op;
  logic        mem_to_reg;
  logic        mem_write;
  logic        is_beq;
  logic        is_bne;
  logic        is_jump;
  logic        is_link;
  logic        is_jr;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_sext;
  logic [31:0] imm_ext;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] dm_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        rf_we;
  logic        dm_we;
  logic        br_taken;

  assign pc4 = pc + 32'd4;

  mips_imem #(.WORDS(IMEM_WORDS)) InstructionMemory (
    .addr  (pc),
    .rdata (instr)
  );

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];

  // Unknown opcodes/functs keep every enable low, so they retire as nops.
  always_comb begin
    reg_write  = 1'b0;
    dst_sel    = DST_RT;
    alu_b_imm  = 1'b0;
    imm_zext   = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_jump    = 1'b0;
    is_link    = 1'b0;
    is_jr      = 1'b0;
    case (op)
      OP_RTYPE: begin
        dst_sel = DST_RD;
        case (funct)
          FN_ADD, FN_ADDU: begin reg_write = 1'b1; alu_op = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin reg_write = 1'b1; alu_op = ALU_SUB;  end
          FN_AND:          begin reg_write = 1'b1; alu_op = ALU_AND;  end
          FN_OR:           begin reg_write = 1'b1; alu_op = ALU_OR;   end
          FN_XOR:          begin reg_write = 1'b1; alu_op = ALU_XOR;  end
          FN_NOR:          begin reg_write = 1'b1; alu_op = ALU_NOR;  end
          FN_SLT:          begin reg_write = 1'b1; alu_op = ALU_SLT;  end
          FN_SLTU:         begin reg_write = 1'b1; alu_op = ALU_SLTU; end
          FN_SLL:          begin reg_write = 1'b1; alu_op = ALU_SLL;  end
          FN_SRL:          begin reg_write = 1'b1; alu_op = ALU_SRL;  end
          FN_SRA:          begin reg_write = 1'b1; alu_op = ALU_SRA;  end
          FN_JR:           is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin reg_write = 1'b1; alu_b_imm = 1'b1; alu_op = ALU_ADD;  end
      OP_SLTI:  begin reg_write = 1'b1; alu_b_imm = 1'b1; alu_op = ALU_SLT;  end
      OP_SLTIU: begin reg_write = 1'b1; alu_b_imm = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin reg_write = 1'b1; alu_b_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin reg_write = 1'b1; alu_b_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR;  end
      OP_XORI:  begin reg_write = 1'b1; alu_b_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:   begin reg_write = 1'b1; alu_op = ALU_LUI; end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_b_imm  = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        alu_b_imm = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: is_beq  = 1'b1;
      OP_BNE: is_bne  = 1'b1;
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump   = 1'b1;
        is_link   = 1'b1;
        reg_write = 1'b1;
        dst_sel   = DST_RA;
      end
      default: ;
    endcase
  end

  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_ext  = imm_zext ? {16'h0000, imm} : imm_sext;

  mips_regfile RegisterFile (
    .clk (clk),
    .we  (rf_we),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wb_addr),
    .wd  (wb_data),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  assign alu_a = rs_val;
  assign alu_b = alu_b_imm ? imm_ext : rt_val;

  always_comb begin
    alu_y = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_NOR:  alu_y = ~(alu_a | alu_b);
      ALU_SLT:  alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_y = {31'd0, (alu_a < alu_b)};
      ALU_SLL:  alu_y = alu_b << shamt;
      ALU_SRL:  alu_y = alu_b >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_y = {imm, 16'h0000};
      default:  alu_y = 32'd0;
    endcase
  end

  mips_dmem #(.WORDS(DMEM_WORDS)) DataMemory (
    .clk   (clk),
    .we    (dm_we),
    .addr  (alu_y),
    .wdata (rt_val),
    .rdata (dm_rdata)
  );

  always_comb begin
    wb_addr = rt;
    case (dst_sel)
      DST_RD:  wb_addr = rd;
      DST_RA:  wb_addr = 5'd31;
      default: wb_addr = rt;
    endcase
  end

  assign wb_data = is_link ? pc4 : (mem_to_reg ? dm_rdata : alu_y);

  // An instruction caught under reset commits nothing.
  assign rf_we = reg_write & ~reset;
  assign dm_we = mem_write & ~reset;

  assign br_taken = (is_beq & (rs_val == rt_val)) | (is_bne & (rs_val != rt_val));

  always_comb begin
    if (is_jr) begin
      pc_next = rs_val;
    end else if (is_jump) begin
      pc_next = {pc4[31:28], instr[25:0], 2'b00};
    end else if (br_taken) begin
      pc_next = pc4 + {imm_sext[29:0], 2'b00};
    end else begin
      pc_next = pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= 32'd0;
    end else begin
      pc <= pc_next;
    end
  end
endmodule

// File: tb/tb_mips_single_cycle.sv
// Directed bench for mips_single_cycle: reset, ALU table, memory, control flow,
// Fibonacci loop and a reset pulse landing on a store.

module tb_mips_single_cycle;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mips_single_cycle #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] instr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_op(int funct, int rd, int rs, int rt, int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(funct)};
  endfunction

  function automatic logic [31:0] i_op(int op, int rt, int rs, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(int op, int target);
    return {6'(op), 26'(target >> 2)};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    dut.InstructionMemory.imem[8'(idx)] = w;
  endtask

  // Holds reset for one edge and blanks imem; caller loads and releases.
  task automatic begin_load();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) put(i, 32'h0);
  endtask

  function automatic logic [31:0] rf(input int r);
    return dut.RegisterFile.regs[5'(r)];
  endfunction

  function automatic logic [31:0] dm(input int w);
    return dut.DataMemory.dmem[8'(w)];
  endfunction

  logic [31:0] pc_trace [18];
  logic [31:0] fib_exp [15];

  initial begin
    pc_trace = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h20, 32'h24, 32'h28,
                 32'h2C, 32'h34, 32'h38, 32'h3C, 32'h50, 32'h54, 32'h40, 32'h44, 32'h44};
    fib_exp = '{32'h1, 32'h1, 32'h2, 32'h3, 32'h5, 32'h8, 32'hd, 32'h15, 32'h22,
                32'h37, 32'h59, 32'h90, 32'he9, 32'h179, 32'h262};

    // a -> $1, b -> $2, result expected in $3 ($3 preset to 5A5A)
    vecs[0]  = '{"add",       32'h5,        32'hFFFFFFFD, r_op(8'h20, 3, 1, 2, 0), 32'h2};
    vecs[1]  = '{"add_wrap",  32'h7FFFFFFF, 32'h1,        r_op(8'h20, 3, 1, 2, 0), 32'h80000000};
    vecs[2]  = '{"sub",       32'h5,        32'hFFFFFFFD, r_op(8'h22, 3, 1, 2, 0), 32'h8};
    vecs[3]  = '{"slt",       32'hFFFFFFFD, 32'h5,        r_op(8'h2A, 3, 1, 2, 0), 32'h1};
    vecs[4]  = '{"sltu_neg",  32'hFFFFFFFD, 32'h5,        r_op(8'h2B, 3, 1, 2, 0), 32'h0};
    vecs[5]  = '{"sltu_pos",  32'h5,        32'hFFFFFFFD, r_op(8'h2B, 3, 1, 2, 0), 32'h1};
    vecs[6]  = '{"and",       32'hF0F01234, 32'h0FF0FF00, r_op(8'h24, 3, 1, 2, 0), 32'h00F01200};
    vecs[7]  = '{"or",        32'hF0F01234, 32'h0FF0FF00, r_op(8'h25, 3, 1, 2, 0), 32'hFFF0FF34};
    vecs[8]  = '{"xor",       32'hF0F01234, 32'h0FF0FF00, r_op(8'h26, 3, 1, 2, 0), 32'hFF00ED34};
    vecs[9]  = '{"nor",       32'hF0F01234, 32'h0FF0FF00, r_op(8'h27, 3, 1, 2, 0), 32'h000F00CB};
    vecs[10] = '{"sll",       32'h0,        32'h80000001, r_op(8'h00, 3, 0, 2, 4), 32'h00000010};
    vecs[11] = '{"srl",       32'h0,        32'h80000010, r_op(8'h02, 3, 0, 2, 4), 32'h08000001};
    vecs[12] = '{"sra",       32'h0,        32'h80000010, r_op(8'h03, 3, 0, 2, 4), 32'hF8000001};
    vecs[13] = '{"addi_neg",  32'h0,        32'h0,        i_op(8'h08, 3, 1, -1),     32'hFFFFFFFF};
    vecs[14] = '{"addiu",     32'h7FFFFFFF, 32'h0,        i_op(8'h09, 3, 1, 16'h7FFF), 32'h80007FFE};
    vecs[15] = '{"slti",      32'hFFFFFFFE, 32'h0,        i_op(8'h0A, 3, 1, -1),     32'h1};
    vecs[16] = '{"sltiu",     32'hFFFFFFFE, 32'h0,        i_op(8'h0B, 3, 1, -1),     32'h1};
    vecs[17] = '{"andi",      32'h12345678, 32'h0,        i_op(8'h0C, 3, 1, 16'hFFFF), 32'h00005678};
    vecs[18] = '{"ori",       32'h0,        32'h0,        i_op(8'h0D, 3, 1, 16'h8000), 32'h00008000};
    vecs[19] = '{"xori",      32'hFFFF0000, 32'h0,        i_op(8'h0E, 3, 1, 16'hFFFF), 32'hFFFFFFFF};
    vecs[20] = '{"lui",       32'h0,        32'h0,        i_op(8'h0F, 3, 0, 16'hABCD), 32'hABCD0000};
    vecs[21] = '{"bad_funct", 32'h1,        32'h2,        r_op(8'h3F, 3, 1, 2, 0), 32'h5A5A};
    vecs[22] = '{"bad_op",    32'h1,        32'h2,        i_op(8'h3F, 3, 1, 16'h1234), 32'h5A5A};

    // Reset held for three edges
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold_pc%0d", i), dut.pc, 32'h0);
    end

    // Program A: ALU, $0, memory, branches, jumps
    for (int i = 0; i < 256; i++) put(i, 32'h0);
    put(0,  i_op(8'h08, 1, 0, 5));
    put(1,  i_op(8'h08, 2, 0, -3));
    put(2,  r_op(8'h20, 3, 1, 2, 0));
    put(3,  r_op(8'h22, 4, 1, 2, 0));
    put(4,  r_op(8'h2A, 5, 2, 1, 0));
    put(5,  r_op(8'h2B, 6, 2, 1, 0));
    put(6,  j_op(8'h02, 32'h20));
    put(7,  i_op(8'h08, 6, 0, 99));
    put(8,  i_op(8'h08, 0, 0, 7));
    put(9,  i_op(8'h2B, 1, 0, 64));
    put(10, i_op(8'h23, 7, 0, 64));
    put(11, i_op(8'h04, 7, 1, 1));
    put(12, i_op(8'h08, 5, 0, 77));
    put(13, i_op(8'h05, 7, 1, 1));
    put(14, i_op(8'h08, 10, 0, 2));
    put(15, j_op(8'h03, 32'h50));
    put(16, i_op(8'h08, 11, 0, 3));
    put(17, j_op(8'h02, 32'h44));
    put(20, i_op(8'h08, 12, 0, 4));
    put(21, r_op(8'h08, 0, 31, 0, 0));
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      check($sformatf("progA_pc_step%0d", i + 1), dut.pc, pc_trace[i]);
    end
    check("add_$3", rf(3), 32'h2);
    check("sub_$4", rf(4), 32'h8);
    check("slt_$5_beq_skip", rf(5), 32'h1);
    check("sltu_$6_j_skip", rf(6), 32'h0);
    check("sw_dmem16", dm(16), 32'h5);
    check("lw_$7", rf(7), 32'h5);
    check("zero_reg_$10", rf(10), 32'h2);
    check("jal_$31", rf(31), 32'h40);
    check("jal_target_$12", rf(12), 32'h4);
    check("jr_return_$11", rf(11), 32'h3);

    // Table: one instruction under test after building operands with lui/ori
    for (int v = 0; v < 23; v++) begin
      begin_load();
      put(0, i_op(8'h0F, 1, 0, int'(vecs[v].a[31:16])));
      put(1, i_op(8'h0D, 1, 1, int'(vecs[v].a[15:0])));
      put(2, i_op(8'h0F, 2, 0, int'(vecs[v].b[31:16])));
      put(3, i_op(8'h0D, 2, 2, int'(vecs[v].b[15:0])));
      put(4, i_op(8'h0D, 3, 0, 16'h5A5A));
      put(5, vecs[v].instr);
      put(6, j_op(8'h02, 32'h18));
      reset = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check({vecs[v].name, "_result"}, rf(3), vecs[v].exp);
      check({vecs[v].name, "_pc"}, dut.pc, 32'h18);
    end

    // Marker in dmem[19] so a suppressed store is observable
    begin_load();
    put(0, i_op(8'h08, 1, 0, 16'h77));
    put(1, i_op(8'h2B, 1, 0, 76));
    put(2, j_op(8'h02, 32'h08));
    reset = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    check("marker_dmem19", dm(19), 32'h77);

    // Fibonacci, interrupted by a reset on the 4th store
    begin_load();
    put(0,  i_op(8'h08, 1, 0, 1));
    put(1,  i_op(8'h08, 2, 0, 1));
    put(2,  i_op(8'h08, 3, 0, 64));
    put(3,  i_op(8'h08, 4, 0, 15));
    put(4,  i_op(8'h2B, 1, 3, 0));
    put(5,  r_op(8'h20, 5, 1, 2, 0));
    put(6,  r_op(8'h21, 1, 0, 2, 0));
    put(7,  r_op(8'h25, 2, 0, 5, 0));
    put(8,  i_op(8'h08, 3, 3, 4));
    put(9,  i_op(8'h08, 4, 4, -1));
    put(10, i_op(8'h05, 0, 4, -7));
    put(11, j_op(8'h02, 32'h54));
    put(21, j_op(8'h02, 32'h54));
    reset = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    check("midrun_pc_before", dut.pc, 32'h10);
    check("midrun_dmem18", dm(18), 32'h2);
    reset = 1'b1;
    tick();
    check("midrun_pc_reset", dut.pc, 32'h0);
    check("midrun_no_store", dm(19), 32'h77);
    reset = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (dut.pc !== 32'h54 && cyc < 300) begin
        tick();
        cyc++;
      end
      check("fib_cycles_to_park", 32'(cyc), 32'd110);
    end
    for (int i = 0; i < 15; i++) begin
      check($sformatf("fib_dmem%0d", 16 + i), dm(16 + i), fib_exp[i]);
    end
    tick();
    tick();
    check("fib_parked_pc", dut.pc, 32'h54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
